// File: rtl/cordic_phase_scheduler_if.sv
// Stream pair between the phase scheduler and the shared CORDIC core:
// phase beats out, {sin, cos} results back.
interface cordic_phase_scheduler_if;
    logic        m_phase_tvalid;
    logic [15:0] m_phase_tdata;
    logic        s_dout_tvalid;
    logic [31:0] s_dout_tdata;

    modport master (
        output m_phase_tvalid,
        output m_phase_tdata,
        input  s_dout_tvalid,
        input  s_dout_tdata
    );

    modport slave (
        input  m_phase_tvalid,
        input  m_phase_tdata,
        output s_dout_tvalid,
        output s_dout_tdata
    );
endinterface

// File: rtl/cordic_phase_scheduler.sv
// Shares one CORDIC core between phase channels A and B: alternating A,B phase
// issue with per-channel wrapping accumulators, results steered back by a tag FIFO.
module cordic_phase_scheduler #(
    parameter int unsigned       CORDIC_LATENCY = 20,
    parameter int unsigned       TAG_DEPTH      = 32,
    parameter logic signed [15:0] PI_POS        = 16'sh6488,
    parameter logic signed [15:0] PI_NEG        = 16'sh9B78
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cfg_load,
    input  logic [15:0]              inc_a,
    input  logic [15:0]              inc_b,
    cordic_phase_scheduler_if.master cor,
    output logic [15:0]              sin_a,
    output logic [15:0]              cos_a,
    output logic                     valid_a,
    output logic [15:0]              sin_b,
    output logic [15:0]              cos_b,
    output logic                     valid_b,
    output logic                     busy,
    output logic                     tag_err
);

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned PTR_W   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(TAG_DEPTH + 1);
    localparam int unsigned DROP_W  = (CORDIC_LATENCY > 0) ? $clog2(CORDIC_LATENCY + 1) : 1;

    localparam logic [CNT_W-1:0]          CNT_LIMIT = CNT_W'(TAG_DEPTH - 2);
    localparam logic [PTR_W-1:0]          PTR_LAST  = PTR_W'(TAG_DEPTH - 1);
    localparam logic [DROP_W-1:0]         DROP_INIT = DROP_W'(CORDIC_LATENCY);
    localparam logic [PHASE_W-1:0]        INC_MAX   = PI_POS;
    localparam logic signed [PHASE_W:0]   PI_POS_X  = {PI_POS[PHASE_W-1], PI_POS};
    localparam logic signed [PHASE_W:0]   PI_NEG_X  = {PI_NEG[PHASE_W-1], PI_NEG};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE_A = 2'd1,
        S_ISSUE_B = 2'd2
    } state_t;

    // One accumulator step in 17-bit signed, folding anything at or above +pi back from -pi.
    function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] acc,
                                                      input logic [PHASE_W-1:0] inc);
        logic [PHASE_W-1:0]      inc_sat;
        logic signed [PHASE_W:0] sum;
        logic signed [PHASE_W:0] wrapped;
        inc_sat = (inc > INC_MAX) ? INC_MAX : inc;
        sum     = $signed({acc[PHASE_W-1], acc}) + $signed({1'b0, inc_sat});
        wrapped = PI_NEG_X + (sum - PI_POS_X);
        return (sum < PI_POS_X) ? sum[PHASE_W-1:0] : wrapped[PHASE_W-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [PHASE_W-1:0]   inc_a_q, inc_a_d, inc_b_q, inc_b_d;
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic [PHASE_W-1:0]   m_tdata_q, m_tdata_d;
    logic [PHASE_W-1:0]   sin_a_q, sin_a_d, cos_a_q, cos_a_d;
    logic [PHASE_W-1:0]   sin_b_q, sin_b_d, cos_b_q, cos_b_d;
    logic                 valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic                 busy_q, busy_d;
    logic                 tag_err_q, tag_err_d;

    logic push, push_tag, pop, pop_tag;

    always_comb begin
        state_d    = state_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        inc_a_d    = inc_a_q;
        inc_b_d    = inc_b_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        m_tdata_d  = m_tdata_q;
        sin_a_d    = sin_a_q;
        cos_a_d    = cos_a_q;
        sin_b_d    = sin_b_q;
        cos_b_d    = cos_b_q;
        valid_a_d  = 1'b0;
        valid_b_d  = 1'b0;
        tag_err_d  = tag_err_q;
        push       = 1'b0;
        push_tag   = 1'b0;
        pop        = cor.s_dout_tvalid && (count_q != '0);
        pop_tag    = tag_mem_q[rd_ptr_q];

        if ((state_q == S_IDLE) && cfg_load) begin
            inc_a_d = inc_a;
            inc_b_d = inc_b;
            acc_a_d = '0;
            acc_b_d = '0;
        end

        // Issue beat: tag goes in with the phase, accumulator advances.
        case (state_q)
            S_ISSUE_A: begin
                push    = 1'b1;
                acc_a_d = phase_step(acc_a_q, inc_a_q);
            end
            S_ISSUE_B: begin
                push     = 1'b1;
                push_tag = 1'b1;
                acc_b_d  = phase_step(acc_b_q, inc_b_q);
            end
            default: ;
        endcase

        if (push) begin
            tag_mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Pairs are never split; FIFO headroom is only checked before an A beat.
        case (state_q)
            S_IDLE: begin
                if (enable && !cfg_load && (count_q <= CNT_LIMIT)) state_d = S_ISSUE_A;
            end
            S_ISSUE_A: state_d = S_ISSUE_B;
            S_ISSUE_B: state_d = (enable && (count_d <= CNT_LIMIT)) ? S_ISSUE_A : S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        m_tvalid_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        if (state_d == S_ISSUE_A) m_tdata_d = acc_a_d;
        else if (state_d == S_ISSUE_B) m_tdata_d = acc_b_d;

        if (pop) begin
            if (pop_tag) begin
                sin_b_d   = cor.s_dout_tdata[31:16];
                cos_b_d   = cor.s_dout_tdata[15:0];
                valid_b_d = 1'b1;
            end else begin
                sin_a_d   = cor.s_dout_tdata[31:16];
                cos_a_d   = cor.s_dout_tdata[15:0];
                valid_a_d = 1'b1;
            end
        end

        // Results still in the core at reset are absorbed while the window is open.
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - DROP_W'(1);
        if (cor.s_dout_tvalid && (count_q == '0) && (drop_cnt_q == '0)) tag_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            inc_a_q    <= '0;
            inc_b_q    <= '0;
            tag_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= DROP_INIT;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            sin_a_q    <= '0;
            cos_a_q    <= '0;
            sin_b_q    <= '0;
            cos_b_q    <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            busy_q     <= 1'b0;
            tag_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            inc_a_q    <= inc_a_d;
            inc_b_q    <= inc_b_d;
            tag_mem_q  <= tag_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            sin_a_q    <= sin_a_d;
            cos_a_q    <= cos_a_d;
            sin_b_q    <= sin_b_d;
            cos_b_q    <= cos_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            busy_q     <= busy_d;
            tag_err_q  <= tag_err_d;
        end
    end

    assign cor.m_phase_tvalid = m_tvalid_q;
    assign cor.m_phase_tdata  = m_tdata_q;
    assign sin_a   = sin_a_q;
    assign cos_a   = cos_a_q;
    assign valid_a = valid_a_q;
    assign sin_b   = sin_b_q;
    assign cos_b   = cos_b_q;
    assign valid_b = valid_b_q;
    assign busy    = busy_q;
    assign tag_err = tag_err_q;

endmodule

// File: tb/tb_cordic_phase_scheduler.sv
// Bench for cordic_phase_scheduler: behavioural CORDIC echo core, phase model and
// result scoreboard checked from a monitor decoupled from the directed stimulus.
module tb_cordic_phase_scheduler;

    localparam int unsigned LAT   = 20;
    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_load;
    logic [15:0] inc_a, inc_b;
    logic [15:0] sin_a, cos_a, sin_b, cos_b;
    logic        valid_a, valid_b, busy, tag_err;

    cordic_phase_scheduler_if cor ();

    cordic_phase_scheduler #(.CORDIC_LATENCY(LAT), .TAG_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .cfg_load (cfg_load),
        .inc_a    (inc_a),
        .inc_b    (inc_b),
        .cor      (cor),
        .sin_a    (sin_a),
        .cos_a    (cos_a),
        .valid_a  (valid_a),
        .sin_b    (sin_b),
        .cos_b    (cos_b),
        .valid_b  (valid_b),
        .busy     (busy),
        .tag_err  (tag_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference phase step in plain integer arithmetic.
    function automatic logic [15:0] ref_step(input logic [15:0] acc, input logic [15:0] inc);
        int s;
        int i;
        i = (int'(inc) > 25736) ? 25736 : int'(inc);
        s = int'($signed(acc)) + i;
        if (s >= 25736) s = s - 25736 - 25736;
        return 16'(s);
    endfunction

    typedef struct packed {
        logic        ch;
        logic [15:0] ph;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_acc_a, m_acc_b, m_inc_a, m_inc_b;
    logic        m_ch;
    logic [15:0] beat_log[6];
    int          nbeat, a_cnt, b_cnt;
    logic [15:0] a_wrap, b_wrap;
    bit          track, stall_seen;

    // Core model state
    int          core_lat;
    int          ncyc;
    int          max_out;
    bit          inject;
    int          due_q[$];
    logic [15:0] dat_q[$];

    // Behavioural core: echoes each phase as {phase, ~phase} core_lat edges later.
    initial begin
        logic [15:0] d;
        cor.s_dout_tvalid = 1'b0;
        cor.s_dout_tdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            cor.s_dout_tvalid = 1'b0;
            cor.s_dout_tdata  = '0;
            if (inject) begin
                cor.s_dout_tvalid = 1'b1;
                cor.s_dout_tdata  = 32'h1234_5678;
                inject = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= ncyc) begin
                void'(due_q.pop_front());
                d = dat_q.pop_front();
                cor.s_dout_tvalid = 1'b1;
                cor.s_dout_tdata  = {d, ~d};
            end
            if (cor.m_phase_tvalid) begin
                due_q.push_back(ncyc + core_lat);
                dat_q.push_back(cor.m_phase_tdata);
            end
            if (track && due_q.size() > max_out) max_out = due_q.size();
        end
    end

    // Monitor: result strobes against the scoreboard, then phase beats against the model.
    always @(negedge clk) begin : mon
        logic        dv;
        logic        expect_v;
        logic [15:0] eph;
        logic [15:0] ecos;
        logic [15:0] got_s;
        logic [15:0] got_c;
        exp_t        e;
        dv       = cor.s_dout_tvalid;
        expect_v = dv && (exp_q.size() > 0);
        check("result_strobe", 32'(valid_a | valid_b), 32'(expect_v));
        if (expect_v && (valid_a || valid_b)) begin
            e     = exp_q.pop_front();
            ecos  = ~e.ph;
            got_s = e.ch ? sin_b : sin_a;
            got_c = e.ch ? cos_b : cos_a;
            check("result_chan", 32'({valid_b, valid_a}), e.ch ? 32'd2 : 32'd1);
            check("result_sin", 32'(got_s), 32'(e.ph));
            check("result_cos", 32'(got_c), 32'(ecos));
        end
        if (cor.m_phase_tvalid) begin
            eph = m_ch ? m_acc_b : m_acc_a;
            check(m_ch ? "phase_b" : "phase_a", 32'(cor.m_phase_tdata), 32'(eph));
            if (nbeat < 6) beat_log[nbeat] = cor.m_phase_tdata;
            nbeat++;
            if (!m_ch) begin
                if (a_cnt == 129) a_wrap = cor.m_phase_tdata;
                a_cnt++;
                m_acc_a = ref_step(m_acc_a, m_inc_a);
            end else begin
                if (b_cnt == 9) b_wrap = cor.m_phase_tdata;
                b_cnt++;
                m_acc_b = ref_step(m_acc_b, m_inc_b);
            end
            exp_q.push_back('{ch: m_ch, ph: eph});
            m_ch = ~m_ch;
        end
        if (track && enable && !cor.m_phase_tvalid) stall_seen = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_cfg(input logic [15:0] a, input logic [15:0] b, input bit accepted);
        inc_a    = a;
        inc_b    = b;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        if (accepted) begin
            m_inc_a = a;
            m_inc_b = b;
            m_acc_a = '0;
            m_acc_b = '0;
        end
    endtask

    initial begin
        logic [15:0] exp6[6];
        int n;
        exp6 = '{16'd0, 16'd0, 16'd200, 16'd3000, 16'd400, 16'd6000};
        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; inc_a = '0; inc_b = '0;
        m_acc_a = '0; m_acc_b = '0; m_inc_a = '0; m_inc_b = '0; m_ch = 1'b0;
        nbeat = 0; a_cnt = 0; b_cnt = 0; a_wrap = '0; b_wrap = '0;
        track = 1'b0; stall_seen = 1'b0; core_lat = LAT; ncyc = 0; max_out = 0; inject = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_tvalid", 32'(cor.m_phase_tvalid), 32'd0);
        check("rst_tdata", 32'(cor.m_phase_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tag_err", 32'(tag_err), 32'd0);
        check("rst_valid", 32'({valid_a, valid_b}), 32'd0);
        check("rst_sincos", {sin_a | sin_b, cos_a | cos_b}, 32'd0);
        reset = 1'b0;
        step();

        // Sweep with inc 200/3000 through both wrap points
        do_cfg(16'd200, 16'd3000, 1'b1);
        enable = 1'b1;
        n = 0;
        while (a_cnt < 131 && n < 400) begin step(); n++; end
        if (n >= 400) timeout_fail("sweep");
        for (int i = 0; i < 6; i++) check("first_beats", 32'(beat_log[i]), 32'(exp6[i]));
        check("wrap_a", 32'(a_wrap), 32'h9BB8);
        check("wrap_b", 32'(b_wrap), 32'hA068);
        check("busy_run", 32'(busy), 32'd1);

        // A and B results on consecutive clocks
        n = 0;
        while (!valid_a && n < 10) begin step(); n++; end
        if (n >= 10) timeout_fail("alt_wait");
        step();
        check("alt_b_follows_a", 32'({valid_a, valid_b}), 32'd1);

        // cfg_load while busy is ignored; model keeps the old increments
        do_cfg(16'd7, 16'd9, 1'b0);
        repeat (4) step();

        // Drop enable with the A beat on the bus: the B beat still goes out
        n = 0;
        while (!(cor.m_phase_tvalid && m_ch) && n < 10) begin step(); n++; end
        if (n >= 10) timeout_fail("issue_a_wait");
        enable = 1'b0;
        step();
        check("pair_b_busy", 32'(busy), 32'd1);
        check("pair_b_tvalid", 32'(cor.m_phase_tvalid), 32'd1);
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tvalid", 32'(cor.m_phase_tvalid), 32'd0);
        repeat (40) step();
        check("drain1", 32'(exp_q.size()), 32'd0);

        // Slow core: FIFO headroom throttles issue at pair boundaries
        core_lat = 40;
        do_cfg(16'd1000, 16'd500, 1'b1);
        max_out = 0; stall_seen = 1'b0; track = 1'b1;
        enable = 1'b1;
        repeat (300) step();
        enable = 1'b0;
        repeat (80) step();
        track = 1'b0;
        check("stall_seen", 32'(stall_seen), 32'd1);
        check("max_in_flight_le_depth", 32'(max_out <= DEPTH), 32'd1);
        check("max_in_flight_ge_30", 32'(max_out >= 30), 32'd1);
        check("drain2", 32'(exp_q.size()), 32'd0);
        check("tag_err_slow", 32'(tag_err), 32'd0);

        // Reset mid-run with results in flight, then one stray result
        core_lat = LAT;
        do_cfg(16'd300, 16'd700, 1'b1);
        enable = 1'b1;
        repeat (40) step();
        reset = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        m_acc_a = '0; m_acc_b = '0; m_inc_a = '0; m_inc_b = '0; m_ch = 1'b0;
        step();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tvalid", 32'(cor.m_phase_tvalid), 32'd0);
        repeat (27) step();
        check("drop_silent", 32'(tag_err), 32'd0);
        inject = 1'b1;
        step();
        step();
        check("tag_err_set", 32'(tag_err), 32'd1);
        repeat (10) step();
        check("tag_err_sticky", 32'(tag_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
